// File: rtl/mux8_pkg.sv
// Shared lane constants and the lane-index type for the 8:1 gather mux and its arbiter.
package mux8_pkg;

  localparam int NUM_LANES = 8;
  localparam int SEL_W     = 3;

  typedef logic [SEL_W-1:0] sel_t;

  function automatic logic [NUM_LANES-1:0] sel_onehot(input sel_t s);
    return NUM_LANES'(1) << s;
  endfunction

endpackage

// File: rtl/rr_arb8.sv
// 8-lane arbiter. Round-robin from pointer p when MUX8_RR_EN is defined,
// otherwise fixed priority with the lowest index winning.
module rr_arb8
  import mux8_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] req,
  input  logic                 en,
  output logic [NUM_LANES-1:0] grant,
  output sel_t                 idx
);

  logic found;
  sel_t pick;

`ifdef MUX8_RR_EN
  sel_t p;
  sel_t cand;

  // Search p, p+1, ... with natural 3-bit wrap from 7 back to 0.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      cand = p + sel_t'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p <= '0;
    end else if (en && found) begin
      p <= pick + sel_t'(1);
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (!found && req[k]) begin
        found = 1'b1;
        pick  = sel_t'(k);
      end
    end
  end
`endif

  always_comb begin
    grant = (en && found) ? sel_onehot(pick) : '0;
    idx   = pick;
  end

endmodule

// File: rtl/mux8_1_arb.sv
// 8:1 arbitrated gather mux with a single registered output slot.
// Arbitration mode is selected by the MUX8_RR_EN macro inside rr_arb8.
module mux8_1_arb
  import mux8_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_LANES-1:0]    in_valid,
  input  logic [NUM_LANES*DW-1:0] in_data,
  output logic [NUM_LANES-1:0]    in_ready,
  output logic                    out_valid,
  output logic [DW-1:0]           out_data,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);

  // Handshake: a word moves on a side when valid and ready are both high at a
  // rising edge; valid never waits on ready, and in_ready is the grant itself.
  logic                 slot_free;
  logic                 accept_en;
  logic [NUM_LANES-1:0] grant;
  sel_t                 grant_idx;
  logic                 take;
  logic [DW-1:0]        sel_data;

  assign slot_free = ~out_valid | out_ready;
  assign accept_en = slot_free & ~rst;

  rr_arb8 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (in_valid),
    .en    (accept_en),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign take     = |grant;
  assign in_ready = grant;
  assign sel_data = in_data[grant_idx*DW +: DW];

  // A load and a drain in the same cycle simply reload, so there is no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
